// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP types: coefficient type, coefficient controller states, default bank
package dsp_pkg;

    localparam int COEF_WIDTH    = 16;
    // Upper bound on taps for the default-bank helper; callers slice what they need.
    localparam int COEF_MAX_TAPS = 64;

    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PEND,
        FLUSH
    } coef_state_e;

    // Q1.15 value closest to +1.0.
    localparam coef_t COEF_UNITY = 16'sh7FFF;

    // Pass-through bank: tap0 = unity, every other tap zero.
    function automatic logic [COEF_MAX_TAPS*COEF_WIDTH-1:0] coef_default_bank(input int taps);
        logic [COEF_MAX_TAPS*COEF_WIDTH-1:0] bank;
        bank = '0;
        if (taps > 0) begin
            bank[COEF_WIDTH-1:0] = COEF_UNITY;
        end
        return bank;
    endfunction

endpackage

// File: rtl/fir_coef_ctrl.sv
// rtl/fir_coef_ctrl.sv - run-time FIR coefficient loader with atomic commit and flush
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_valid/ready   coefficient word handshake; cfg_data tap 0 first, cfg_last ends a load
//   sample_valid      FIR input strobe; commit waits for a cycle where it is low
//   coef_flat         active bank, tap k at [k*COEF_W +: COEF_W]
//   coef_update       one-cycle pulse when coef_flat changes
//   fir_flush         high for TAPS cycles after a commit
//   cfg_err           one-cycle pulse when a load is rejected
//   busy              controller not idle
//   commit_count      saturating count of commits
module fir_coef_ctrl
    import dsp_pkg::*;
#(
    parameter int TAPS   = 4,
    parameter int COEF_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    input  logic signed [COEF_W-1:0] cfg_data,
    input  logic                     cfg_last,
    output logic                     cfg_ready,
    input  logic                     sample_valid,
    output logic [TAPS*COEF_W-1:0]   coef_flat,
    output logic                     coef_update,
    output logic                     fir_flush,
    output logic                     cfg_err,
    output logic                     busy,
    output logic [7:0]               commit_count
);

    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CNT_W = $clog2(TAPS + 1);

    localparam logic [COEF_MAX_TAPS*COEF_WIDTH-1:0] DEFAULT_FULL = coef_default_bank(TAPS);
    localparam logic [TAPS*COEF_W-1:0]              DEFAULT_BANK = DEFAULT_FULL[TAPS*COEF_W-1:0];
    localparam logic [IDX_W-1:0]                    LAST_IDX     = IDX_W'(TAPS - 1);
    localparam logic [CNT_W-1:0]                    FLUSH_LEN    = CNT_W'(TAPS);

    coef_state_e               state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [CNT_W-1:0]          flush_cnt_q;
    logic [TAPS*COEF_W-1:0]    shadow_q;
    logic [TAPS*COEF_W-1:0]    coef_flat_q;
    logic                      coef_update_q;
    logic                      fir_flush_q;
    logic                      cfg_err_q;
    logic [7:0]                commit_count_q;
    logic                      accept;

    assign cfg_ready    = (state_q == IDLE) || (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign accept       = cfg_valid && cfg_ready;

    assign coef_flat    = coef_flat_q;
    assign coef_update  = coef_update_q;
    assign fir_flush    = fir_flush_q;
    assign cfg_err      = cfg_err_q;
    assign commit_count = commit_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            flush_cnt_q    <= '0;
            shadow_q       <= '0;
            coef_flat_q    <= DEFAULT_BANK;
            coef_update_q  <= 1'b0;
            fir_flush_q    <= 1'b0;
            cfg_err_q      <= 1'b0;
            commit_count_q <= '0;
        end else begin
            coef_update_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shadow_q[COEF_W-1:0] <= cfg_data;
                        if (cfg_last) begin
                            // A one-word load can never fill a bank of two or more taps.
                            cfg_err_q <= 1'b1;
                            idx_q     <= '0;
                        end else begin
                            idx_q   <= IDX_W'(1);
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shadow_q[int'(idx_q)*COEF_W +: COEF_W] <= cfg_data;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            if (cfg_last) begin
                                state_q <= PEND;
                            end else begin
                                cfg_err_q <= 1'b1;
                                state_q   <= IDLE;
                            end
                        end else if (cfg_last) begin
                            cfg_err_q <= 1'b1;
                            idx_q     <= '0;
                            state_q   <= IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                PEND: begin
                    // Swap only when no sample enters the FIR this cycle.
                    if (!sample_valid) begin
                        coef_flat_q   <= shadow_q;
                        coef_update_q <= 1'b1;
                        fir_flush_q   <= 1'b1;
                        flush_cnt_q   <= FLUSH_LEN;
                        if (commit_count_q != 8'hFF) begin
                            commit_count_q <= commit_count_q + 8'd1;
                        end
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Counter holds the flush cycles still to be shown, including this one.
                    flush_cnt_q <= flush_cnt_q - 1'b1;
                    if (flush_cnt_q == CNT_W'(1)) begin
                        fir_flush_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb/tb_fir_coef_ctrl.sv - self-checking bench for fir_coef_ctrl
module tb_fir_coef_ctrl;

    localparam int TAPS = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic signed [15:0] cfg_data = '0;
    logic               cfg_last = 1'b0;
    logic               cfg_ready;
    logic               sample_valid = 1'b0;
    logic [63:0]        coef_flat;
    logic               coef_update;
    logic               fir_flush;
    logic               cfg_err;
    logic               busy;
    logic [7:0]         commit_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fir_coef_ctrl #(.TAPS(TAPS), .COEF_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
        .sample_valid(sample_valid),
        .coef_flat(coef_flat), .coef_update(coef_update), .fir_flush(fir_flush),
        .cfg_err(cfg_err), .busy(busy), .commit_count(commit_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: words collected into a list, a bank swap when the list is complete
    // and the FIR is quiet, then TAPS flush cycles.
    logic [15:0] m_words[$];
    logic [15:0] m_bank[TAPS];
    int          m_phase;       // 0 collecting, 1 waiting to commit, 2 flushing
    int          m_left;
    int          m_count;
    bit          m_upd, m_err;
    int          cyc = 0;
    int          last_acc_edge = 0;
    int          upd_edge = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_words.delete();
            m_bank  = '{16'h7FFF, 16'h0, 16'h0, 16'h0};
            m_phase = 0;
            m_left  = 0;
            m_count = 0;
            m_upd   = 0;
            m_err   = 0;
        end else begin
            cyc++;
            m_upd = 0;
            m_err = 0;
            if (m_phase == 0) begin
                if (cfg_valid) begin
                    m_words.push_back(cfg_data);
                    if (cfg_last) begin
                        if (m_words.size() == TAPS) begin
                            m_phase = 1;
                            last_acc_edge = cyc;
                        end else begin
                            m_err = 1;
                            m_words.delete();
                        end
                    end else if (m_words.size() == TAPS) begin
                        m_err = 1;
                        m_words.delete();
                    end
                end
            end else if (m_phase == 1) begin
                if (!sample_valid) begin
                    for (int k = 0; k < TAPS; k++) m_bank[k] = m_words[k];
                    m_words.delete();
                    m_upd   = 1;
                    m_count = (m_count < 255) ? m_count + 1 : 255;
                    m_left  = TAPS;
                    m_phase = 2;
                    upd_edge = cyc;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        end
    end

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        for (int k = 0; k < TAPS; k++) f[k*16 +: 16] = m_bank[k];
        return f;
    endfunction

    int flush_len = 0;
    int err_seen = 0;

    always @(negedge clk) begin
        chk("coef_flat", coef_flat, model_flat());
        chk("coef_update", 64'(coef_update), 64'(m_upd));
        chk("fir_flush", 64'(fir_flush), 64'(m_phase == 2));
        chk("cfg_err", 64'(cfg_err), 64'(m_err));
        chk("cfg_ready", 64'(cfg_ready), 64'(m_phase == 0));
        chk("busy", 64'(busy), 64'(m_phase != 0 || m_words.size() != 0));
        chk("commit_count", 64'(commit_count), 64'(m_count));
        if (fir_flush) flush_len++;
        if (cfg_err) err_seen++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        step();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic load4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            if (!busy) done = 1;
        end
        chk({name, "_idle_timeout"}, 64'(done), 64'd1);
    endtask

    initial begin
        step();
        step();
        #1;
        chk("reset_flat", coef_flat, 64'h0000_0000_0000_7FFF);
        chk("reset_count", 64'(commit_count), 64'd0);
        chk("reset_ready", 64'(cfg_ready), 64'd1);
        rst_n = 1'b1;
        repeat (10) step();
        chk("idle_flat", coef_flat, 64'h0000_0000_0000_7FFF);

        // Back-to-back load, FIR quiet.
        flush_len = 0;
        load4(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        wait_idle("load1");
        chk("load1_flat", coef_flat, 64'h4000_3000_2000_1000);
        chk("load1_latency", 64'(upd_edge - last_acc_edge), 64'd1);
        chk("load1_flush_len", 64'(flush_len), 64'd4);
        chk("load1_count", 64'(commit_count), 64'd1);

        // Commit held off while samples keep arriving.
        sample_valid = 1'b1;
        load4(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        repeat (7) step();
        chk("hold_ready", 64'(cfg_ready), 64'd0);
        sample_valid = 1'b0;
        wait_idle("hold");
        chk("hold_latency", 64'(upd_edge - last_acc_edge), 64'd8);
        chk("hold_count", 64'(commit_count), 64'd2);

        // Short load, then long load (5th word carries cfg_last and is itself rejected).
        err_seen = 0;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        send(16'h0A0A, 1'b0);
        send(16'h0B0B, 1'b0);
        send(16'h0C0C, 1'b0);
        send(16'h0D0D, 1'b0);
        send(16'h0E0E, 1'b1);
        repeat (3) step();
        chk("err_pulses", 64'(err_seen), 64'd3);
        chk("err_flat", coef_flat, 64'h4000_3000_2000_1000);
        chk("err_count", 64'(commit_count), 64'd2);
        load4(16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF);
        wait_idle("after_err");
        chk("after_err_flat", coef_flat, 64'h7FFF_0001_8000_FFFF);
        chk("after_err_count", 64'(commit_count), 64'd3);

        // Reset during LOAD.
        send(16'h5555, 1'b0);
        send(16'h6666, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_load_flat", coef_flat, 64'h0000_0000_0000_7FFF);
        chk("rst_load_count", 64'(commit_count), 64'd0);
        chk("rst_load_busy", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Reset in the second flush cycle.
        load4(16'h0123, 16'h0456, 16'h0789, 16'h0ABC);
        step();
        step();
        chk("pre_rst_flush", 64'(fir_flush), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_flush_flush", 64'(fir_flush), 64'd0);
        chk("rst_flush_flat", coef_flat, 64'h0000_0000_0000_7FFF);
        chk("rst_flush_count", 64'(commit_count), 64'd0);
        chk("rst_flush_ready", 64'(cfg_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // Saturation of the commit counter.
        for (int i = 0; i < 260; i++) begin
            load4(16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3));
            wait_idle("sat");
        end
        chk("sat_count", 64'(commit_count), 64'd255);
        chk("sat_flat", coef_flat, 64'h0106_0105_0104_0103);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
